// File: rtl/fibonacci_circuit.sv
// fibonacci_circuit: iterative F(i) calculator, one add per clock, ready/start/done_tick handshake.
// Define FIBO_SAT_EN to saturate the add at all-ones instead of wrapping.
module fibonacci_circuit #(
    parameter int N_W = 5,
    parameter int F_W = 20
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [N_W-1:0] i_i,
    output logic           ready_o,
    output logic           done_tick_o,
    output logic [F_W-1:0] f_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OP   = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state_reg, state_next;
    logic [F_W-1:0] t0_reg, t0_next, t1_reg, t1_next, add_res;
    logic [N_W-1:0] n_reg, n_next;

`ifdef FIBO_SAT_EN
    logic [F_W:0] sum;
    // Once t1 is all-ones every later add carries out again, so saturation stays sticky.
    assign sum     = {1'b0, t1_reg} + {1'b0, t0_reg};
    assign add_res = sum[F_W] ? {F_W{1'b1}} : sum[F_W-1:0];
`else
    assign add_res = t1_reg + t0_reg;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            t0_reg    <= '0;
            t1_reg    <= '0;
            n_reg     <= '0;
        end else begin
            state_reg <= state_next;
            t0_reg    <= t0_next;
            t1_reg    <= t1_next;
            n_reg     <= n_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        t0_next    = t0_reg;
        t1_next    = t1_reg;
        n_next     = n_reg;
        if (state_reg == IDLE) begin
            if (start_i) begin
                t0_next    = '0;
                t1_next    = {{(F_W-1){1'b0}}, 1'b1};
                n_next     = i_i;
                state_next = OP;
            end
        end else if (state_reg == OP) begin
            if (n_reg == '0) begin
                t1_next    = '0;
                state_next = DONE;
            end else if (n_reg == {{(N_W-1){1'b0}}, 1'b1}) begin
                state_next = DONE;
            end else begin
                t1_next = add_res;
                t0_next = t1_reg;
                n_next  = n_reg - 1'b1;
            end
        end else begin
            state_next = IDLE;
        end
    end

    assign ready_o     = (state_reg == IDLE);
    assign done_tick_o = (state_reg == DONE);
    assign f_o         = t1_reg;
endmodule

// File: tb/tb_fibonacci_circuit.sv
// tb_fibonacci_circuit: directed checks of result, latency, busy-ignore and async reset.
module tb_fibonacci_circuit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [4:0]  i_i = '0;
    logic        ready_o, done_tick_o;
    logic [19:0] f_o;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat;

    fibonacci_circuit dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .i_i(i_i),
        .ready_o(ready_o), .done_tick_o(done_tick_o), .f_o(f_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [4:0] idx);
        @(negedge clk_i);
        check("ready_before_start", 32'(ready_o), 32'd1);
        start_i = 1'b1;
        i_i     = idx;
        @(negedge clk_i);
        start_i = 1'b0;
        i_i     = '0;
        lat     = 1;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp_f, input int exp_lat);
        while (!done_tick_o && lat < 100) begin
            @(negedge clk_i);
            lat++;
        end
        check({tag, "_done"}, 32'(done_tick_o), 32'd1);
        check({tag, "_f"}, 32'(f_o), exp_f);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        @(negedge clk_i);
        check({tag, "_pulse_end"}, 32'(done_tick_o), 32'd0);
        check({tag, "_ready_after"}, 32'(ready_o), 32'd1);
        check({tag, "_f_hold"}, 32'(f_o), exp_f);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_done", 32'(done_tick_o), 32'd0);
        check("rst_f", 32'(f_o), 32'd0);
        check("rst_state", 32'(dut.state_reg), 32'd0);
        rst_i = 1'b1;

        start_run(5'd0);
        check("i0_busy", 32'(ready_o), 32'd0);
        wait_done("i0", 32'd0, 2);
        start_run(5'd1);
        wait_done("i1", 32'd1, 2);
        start_run(5'd5);
        wait_done("i5", 32'd5, 6);
        start_run(5'd2);
        wait_done("i2", 32'd1, 3);
        start_run(5'd30);
        wait_done("i30", 32'd832040, 31);
        start_run(5'd31);
`ifdef FIBO_SAT_EN
        wait_done("i31", 32'd1048575, 32);
`else
        wait_done("i31", 32'd297693, 32);
`endif

        start_run(5'd10);
        start_i = 1'b1;
        i_i     = 5'd3;
        @(negedge clk_i);
        lat++;
        start_i = 1'b0;
        i_i     = '0;
        wait_done("busy_i10", 32'd55, 11);

        start_run(5'd20);
        repeat (5) @(negedge clk_i);
        check("mid_op_busy", 32'(ready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("async_rst_ready", 32'(ready_o), 32'd1);
        check("async_rst_f", 32'(f_o), 32'd0);
        check("async_rst_state", 32'(dut.state_reg), 32'd0);
        repeat (2) begin
            @(negedge clk_i);
            check("async_rst_no_done", 32'(done_tick_o), 32'd0);
        end
        rst_i = 1'b1;
        start_run(5'd20);
        wait_done("i20", 32'd6765, 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
